// File: rtl/isp_frame_gain.sv
// isp_frame_gain: per-channel white-balance gain stage for a raster pixel stream.
// Configuration is captured on the first beat of each frame and held until
// the frame ends. Row length is tracked against the configured frame width.
// Per-frame row totals are reported when the frame's last beat leaves the block.
// The datapath is two register stages deep: stage 1 captures the beat and the
// frame-level bookkeeping, stage 2 applies gain and drives the outputs.
module isp_frame_gain #(
  parameter int COLOR_DEPTH = 8,
  parameter int GAIN_W      = 8,
  parameter int GAIN_FRAC   = 6,
  parameter int COL_W       = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [COLOR_DEPTH-1:0] pixel_in,
  input  logic                   valid_in,
  input  logic [1:0]             color_in,
  input  logic                   last_col_in,
  input  logic                   last_pic_in,
  input  logic [3:0]             mode,
  input  logic [GAIN_W-1:0]      gain_r,
  input  logic [GAIN_W-1:0]      gain_g,
  input  logic [GAIN_W-1:0]      gain_b,
  input  logic [COL_W-1:0]       frame_cols,
  output logic [COLOR_DEPTH-1:0] pixel_out,
  output logic                   valid_out,
  output logic [1:0]             color_out,
  output logic                   last_col_out,
  output logic                   last_pic_out,
  output logic                   frame_done,
  output logic                   size_err,
  output logic [COL_W-1:0]       row_count
);

  localparam int PW = COLOR_DEPTH + GAIN_W;
  localparam int unsigned HALF_I = (GAIN_FRAC > 0) ? (32'd1 << (GAIN_FRAC - 1)) : 32'd0;
  localparam logic [PW:0] HALF_C = (PW+1)'(HALF_I);
  localparam logic [PW:0] MAX_C  = {{(PW+1-COLOR_DEPTH){1'b0}}, {COLOR_DEPTH{1'b1}}};

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [COL_W-1:0] sat_inc(input logic [COL_W-1:0] v);
    if (v == {COL_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(COL_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Fixed-point multiply with round-half-up and clamp to the pixel range.
  // The rounding add gets one extra bit so a full-scale product cannot wrap.
  function automatic logic [COLOR_DEPTH-1:0] apply_gain(
    input logic [COLOR_DEPTH-1:0] pix,
    input logic [GAIN_W-1:0]      g
  );
    logic [PW-1:0] prod;
    logic [PW:0]   rnd;
    logic [PW:0]   shifted;
    prod    = PW'(pix) * PW'(g);
    rnd     = {1'b0, prod} + HALF_C;
    shifted = rnd >> GAIN_FRAC;
    if (shifted > MAX_C) begin
      apply_gain = {COLOR_DEPTH{1'b1}};
    end else begin
      apply_gain = shifted[COLOR_DEPTH-1:0];
    end
  endfunction

  // Frame state and shadow configuration
  state_t            state_r;
  logic [2:0]        sh_mode_r;
  logic [GAIN_W-1:0] sh_gain_r_r;
  logic [GAIN_W-1:0] sh_gain_g_r;
  logic [GAIN_W-1:0] sh_gain_b_r;
  logic [COL_W-1:0]  sh_cols_r;

  // Row/column bookkeeping
  logic [COL_W-1:0]  col_cnt_r;
  logic [COL_W-1:0]  row_cnt_r;

  // Stage 1 registers
  logic                   s1_valid_r;
  logic [COLOR_DEPTH-1:0] s1_pixel_r;
  logic [1:0]             s1_color_r;
  logic                   s1_last_col_r;
  logic                   s1_last_pic_r;
  logic                   s1_bypass_r;
  logic                   s1_gain_en_r;
  logic [GAIN_W-1:0]      s1_gain_r;
  logic                   s1_first_r;
  logic                   s1_err_r;
  logic [COL_W-1:0]       s1_rows_r;

  // Output registers
  logic [COLOR_DEPTH-1:0] pixel_out_r;
  logic                   valid_out_r;
  logic [1:0]             color_out_r;
  logic                   last_col_out_r;
  logic                   last_pic_out_r;
  logic                   frame_done_r;
  logic                   size_err_r;
  logic [COL_W-1:0]       row_count_r;

  // Stage 0 combinational decode
  logic                   first_s;
  logic [2:0]             mode_eff_s;
  logic [GAIN_W-1:0]      gain_r_eff_s;
  logic [GAIN_W-1:0]      gain_g_eff_s;
  logic [GAIN_W-1:0]      gain_b_eff_s;
  logic [COL_W-1:0]       cols_eff_s;
  logic [GAIN_W-1:0]      gain_sel_s;
  logic                   row_end_s;
  logic [COL_W:0]         cnt_p1_s;
  logic                   err_evt_s;
  logic [COL_W-1:0]       rows_total_s;
  logic [COLOR_DEPTH-1:0] pix_proc_s;

  // mode[3] is reserved and intentionally has no effect.
  logic unused_mode_s;
  assign unused_mode_s = mode[3];

  // Pick live config on a frame's first beat, shadow config otherwise; derive row checks.
  always_comb begin
    first_s      = (state_r == IDLE) && valid_in;
    mode_eff_s   = sh_mode_r;
    gain_r_eff_s = sh_gain_r_r;
    gain_g_eff_s = sh_gain_g_r;
    gain_b_eff_s = sh_gain_b_r;
    cols_eff_s   = sh_cols_r;
    if (state_r == IDLE) begin
      mode_eff_s   = mode[2:0];
      gain_r_eff_s = gain_r;
      gain_g_eff_s = gain_g;
      gain_b_eff_s = gain_b;
      cols_eff_s   = frame_cols;
    end else begin
      mode_eff_s   = sh_mode_r;
    end

    case (color_in)
      2'b00:   gain_sel_s = gain_r_eff_s;
      2'b01:   gain_sel_s = gain_g_eff_s;
      2'b10:   gain_sel_s = gain_b_eff_s;
      default: gain_sel_s = {GAIN_W{1'b0}};
    endcase

    // A frame end without a column marker still closes the row.
    row_end_s    = last_col_in | last_pic_in;
    cnt_p1_s     = {1'b0, col_cnt_r} + {{COL_W{1'b0}}, 1'b1};
    rows_total_s = sat_inc(row_cnt_r);

    err_evt_s = 1'b0;
    if (valid_in && mode_eff_s[2]) begin
      if (row_end_s) begin
        err_evt_s = (cnt_p1_s != {1'b0, cols_eff_s});
      end else begin
        err_evt_s = (cnt_p1_s == {1'b0, cols_eff_s});
      end
    end else begin
      err_evt_s = 1'b0;
    end
  end

  // Frame FSM: capture configuration on the first beat, release it after the last.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r     <= IDLE;
      sh_mode_r   <= 3'b000;
      sh_gain_r_r <= {GAIN_W{1'b0}};
      sh_gain_g_r <= {GAIN_W{1'b0}};
      sh_gain_b_r <= {GAIN_W{1'b0}};
      sh_cols_r   <= {COL_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (valid_in) begin
            sh_mode_r   <= mode[2:0];
            sh_gain_r_r <= gain_r;
            sh_gain_g_r <= gain_g;
            sh_gain_b_r <= gain_b;
            sh_cols_r   <= frame_cols;
            state_r     <= last_pic_in ? IDLE : ACTIVE;
          end else begin
            state_r     <= IDLE;
          end
        end
        ACTIVE: begin
          if (valid_in && last_pic_in) begin
            state_r <= IDLE;
          end else begin
            state_r <= ACTIVE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Column and row counters; both restart after the frame's last beat.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      col_cnt_r <= {COL_W{1'b0}};
      row_cnt_r <= {COL_W{1'b0}};
    end else if (valid_in) begin
      if (row_end_s) begin
        col_cnt_r <= {COL_W{1'b0}};
        row_cnt_r <= last_pic_in ? {COL_W{1'b0}} : rows_total_s;
      end else begin
        col_cnt_r <= sat_inc(col_cnt_r);
      end
    end else begin
      col_cnt_r <= col_cnt_r;
    end
  end

  // Stage 1: capture the beat together with its resolved gain and frame bookkeeping.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_valid_r    <= 1'b0;
      s1_pixel_r    <= {COLOR_DEPTH{1'b0}};
      s1_color_r    <= 2'b00;
      s1_last_col_r <= 1'b0;
      s1_last_pic_r <= 1'b0;
      s1_bypass_r   <= 1'b0;
      s1_gain_en_r  <= 1'b0;
      s1_gain_r     <= {GAIN_W{1'b0}};
      s1_first_r    <= 1'b0;
      s1_err_r      <= 1'b0;
      s1_rows_r     <= {COL_W{1'b0}};
    end else begin
      s1_valid_r    <= valid_in;
      s1_pixel_r    <= pixel_in;
      s1_color_r    <= color_in;
      s1_last_col_r <= last_col_in;
      s1_last_pic_r <= last_pic_in;
      s1_bypass_r   <= mode_eff_s[0];
      s1_gain_en_r  <= mode_eff_s[1];
      s1_gain_r     <= gain_sel_s;
      s1_first_r    <= first_s;
      s1_err_r      <= err_evt_s;
      s1_rows_r     <= rows_total_s;
    end
  end

  // Stage 2 pixel function: bypass wins, reserved colour and gain-off pass through.
  always_comb begin
    if (s1_bypass_r) begin
      pix_proc_s = s1_pixel_r;
    end else if (s1_gain_en_r && (s1_color_r != 2'b11)) begin
      pix_proc_s = apply_gain(s1_pixel_r, s1_gain_r);
    end else begin
      pix_proc_s = s1_pixel_r;
    end
  end

  // Stage 2: register the processed beat and frame status outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pixel_out_r    <= {COLOR_DEPTH{1'b0}};
      valid_out_r    <= 1'b0;
      color_out_r    <= 2'b00;
      last_col_out_r <= 1'b0;
      last_pic_out_r <= 1'b0;
      frame_done_r   <= 1'b0;
      size_err_r     <= 1'b0;
      row_count_r    <= {COL_W{1'b0}};
    end else begin
      pixel_out_r    <= pix_proc_s;
      valid_out_r    <= s1_valid_r;
      color_out_r    <= s1_color_r;
      last_col_out_r <= s1_last_col_r;
      last_pic_out_r <= s1_last_pic_r;
      frame_done_r   <= s1_valid_r & s1_last_pic_r;
      if (s1_valid_r && s1_first_r) begin
        size_err_r <= s1_err_r;
      end else if (s1_valid_r && s1_err_r) begin
        size_err_r <= 1'b1;
      end else begin
        size_err_r <= size_err_r;
      end
      if (s1_valid_r && s1_last_pic_r) begin
        row_count_r <= s1_rows_r;
      end else begin
        row_count_r <= row_count_r;
      end
    end
  end

  assign pixel_out    = pixel_out_r;
  assign valid_out    = valid_out_r;
  assign color_out    = color_out_r;
  assign last_col_out = last_col_out_r;
  assign last_pic_out = last_pic_out_r;
  assign frame_done   = frame_done_r;
  assign size_err     = size_err_r;
  assign row_count    = row_count_r;

endmodule

// File: tb/tb_isp_frame_gain.sv
// Scoreboard bench for isp_frame_gain: directed frames plus randomized frames,
// expected beats produced by a frame-level reference model.
module tb_isp_frame_gain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pixel_in;
  logic        valid_in;
  logic [1:0]  color_in;
  logic        last_col_in;
  logic        last_pic_in;
  logic [3:0]  mode;
  logic [7:0]  gain_r, gain_g, gain_b;
  logic [11:0] frame_cols;
  logic [7:0]  pixel_out;
  logic        valid_out;
  logic [1:0]  color_out;
  logic        last_col_out;
  logic        last_pic_out;
  logic        frame_done;
  logic        size_err;
  logic [11:0] row_count;

  always #5 clk = ~clk;

  isp_frame_gain dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
    .color_in(color_in), .last_col_in(last_col_in), .last_pic_in(last_pic_in),
    .mode(mode), .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b),
    .frame_cols(frame_cols), .pixel_out(pixel_out), .valid_out(valid_out),
    .color_out(color_out), .last_col_out(last_col_out), .last_pic_out(last_pic_out),
    .frame_done(frame_done), .size_err(size_err), .row_count(row_count)
  );

  typedef struct packed {
    logic [7:0]  pix;
    logic [1:0]  color;
    logic        lc;
    logic        lp;
    logic        fd;
    logic        serr;
    logic [11:0] rows;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  // reference model state
  bit       m_in_frame;
  bit [3:0] m_mode;
  int       m_g[3];
  int       m_cols, m_col, m_row, m_last_rows;
  bit       m_err;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0; m_mode = 4'd0; m_cols = 0; m_col = 0; m_row = 0;
    m_last_rows = 0; m_err = 1'b0;
    for (int i = 0; i < 3; i++) m_g[i] = 0;
  endtask

  // One valid beat through the reference model; returns nothing, pushes expectation.
  task automatic model_beat(input int p, input int c, input bit lc, input bit lp);
    exp_t e;
    int   outp;
    int   v;
    bit   row_end;
    if (!m_in_frame) begin
      m_mode = mode; m_g[0] = gain_r; m_g[1] = gain_g; m_g[2] = gain_b;
      m_cols = frame_cols; m_col = 0; m_row = 0; m_err = 1'b0; m_in_frame = 1'b1;
    end
    if (m_mode[0] || !m_mode[1] || c == 3) begin
      outp = p;
    end else begin
      v = (p * m_g[c] + 32) / 64;
      outp = (v > 255) ? 255 : v;
    end
    row_end = lc | lp;
    if (m_mode[2]) begin
      if (row_end && (m_col + 1 != m_cols)) m_err = 1'b1;
      if (!row_end && (m_col + 1 == m_cols)) m_err = 1'b1;
    end
    if (row_end) begin
      m_col = 0;
      m_row = (m_row + 1 > 4095) ? 4095 : m_row + 1;
    end else begin
      m_col = (m_col + 1 > 4095) ? 4095 : m_col + 1;
    end
    if (lp) begin
      m_last_rows = m_row;
      m_in_frame  = 1'b0;
    end
    e.pix = outp[7:0]; e.color = c[1:0]; e.lc = lc; e.lp = lp; e.fd = lp;
    e.serr = m_err; e.rows = m_last_rows[11:0];
    q.push_back(e);
  endtask

  task automatic beat(input int p, input int c, input bit lc, input bit lp);
    @(posedge clk); #1;
    pixel_in = p[7:0]; color_in = c[1:0]; last_col_in = lc; last_pic_in = lp;
    valid_in = 1'b1;
    model_beat(p, c, lc, lp);
  endtask

  // Idle cycle; configuration may be changed safely right after this returns.
  task automatic bubble();
    @(posedge clk); #1;
    valid_in = 1'b0; pixel_in = 8'($urandom); color_in = 2'($urandom);
    last_col_in = 1'($urandom); last_pic_in = 1'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    valid_in = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    q.delete();
    model_reset();
    @(negedge clk);
    chk("reset_valid_out", 64'(valid_out), 64'd0);
    chk("reset_outputs", 64'({pixel_out, color_out, last_col_out, last_pic_out}), 64'd0);
    chk("reset_status", 64'({frame_done, size_err, row_count}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
  endtask

  // A frame of rows x cols beats, all rows well-formed, optional bubbles.
  task automatic frame(input int rows, input int cols, input int col_seed, input bit bubbles);
    for (int r = 0; r < rows; r++) begin
      for (int b = 0; b < cols; b++) begin
        if (bubbles && (b % 2 == 1)) bubble();
        beat((r * 16 + b * 7 + col_seed) % 256, (b + col_seed) % 3,
             b == cols - 1, (r == rows - 1) && (b == cols - 1));
      end
    end
  endtask

  // Monitor: pop the scoreboard on every output beat, idle cycles must not pulse frame_done.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (valid_out === 1'b1) begin
          if (q.size() == 0) begin
            chk("unexpected_valid_out", 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_beat", 64'({pixel_out, color_out, last_col_out, last_pic_out,
                                 frame_done, size_err, row_count}), 64'(e));
          end
        end else begin
          chk("idle_no_frame_done", 64'({valid_out, frame_done}), 64'd0);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; valid_in = 1'b0; pixel_in = 8'd0; color_in = 2'd0;
    last_col_in = 1'b0; last_pic_in = 1'b0; mode = 4'd0;
    gain_r = 8'd64; gain_g = 8'd64; gain_b = 8'd64; frame_cols = 12'd4;
    model_reset();
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    do_reset();

    // gain path with rounding and saturation
    bubble(); mode = 4'b0010; gain_r = 8'd128;
    beat(100, 0, 1'b0, 1'b0);
    beat(200, 0, 1'b1, 1'b1);

    // bypass beats gain; reserved colour passes through
    bubble(); mode = 4'b0011; gain_g = 8'd0;
    beat(77, 1, 1'b1, 1'b1);
    bubble(); mode = 4'b0010;
    beat(123, 3, 1'b0, 1'b0);
    beat(50, 1, 1'b1, 1'b1);

    // configuration captured at frame start, mid-frame changes ignored
    bubble(); mode = 4'b0010; gain_b = 8'd64;
    beat(80, 2, 1'b0, 1'b0);
    bubble(); gain_b = 8'd32; mode = 4'b0001;
    beat(80, 2, 1'b1, 1'b1);
    bubble(); mode = 4'b0010;
    beat(80, 2, 1'b1, 1'b1);

    // size check: short row sets sticky error, next frame's first beat clears it
    bubble(); mode = 4'b0100; frame_cols = 12'd4;
    for (int b = 0; b < 3; b++) beat(b, 0, b == 2, 1'b0);
    for (int b = 0; b < 4; b++) beat(b, 1, b == 3, 1'b0);
    for (int b = 0; b < 4; b++) beat(b, 2, b == 3, b == 3);
    bubble(); bubble();
    frame(1, 4, 3, 1'b0);

    // 3x4 frame with bubbles, frame_done and row_count
    bubble(); mode = 4'b0000;
    frame(3, 4, 1, 1'b1);
    // single-beat frame, and last_pic without last_col closing a row
    bubble(); mode = 4'b0100; frame_cols = 12'd1;
    beat(9, 0, 1'b0, 1'b1);
    bubble(); frame_cols = 12'd2;
    beat(1, 0, 1'b1, 1'b0);
    beat(2, 0, 1'b0, 1'b0);
    beat(3, 0, 1'b0, 1'b1);

    // reset mid-frame after 5 beats, then a clean frame counts from zero
    bubble(); mode = 4'b0100; frame_cols = 12'd4;
    for (int b = 0; b < 5; b++) beat(b + 10, 0, b == 3, 1'b0);
    do_reset();
    bubble(); bubble();
    frame(2, 4, 5, 1'b1);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      int  rows, cols, len;
      bit  abort;
      bubble();
      mode = 4'($urandom); frame_cols = 12'($urandom_range(1, 5));
      gain_r = 8'($urandom); gain_g = 8'($urandom_range(0, 130)); gain_b = 8'($urandom);
      rows = $urandom_range(1, 3);
      cols = frame_cols;
      abort = 1'b0;
      for (int r = 0; r < rows && !abort; r++) begin
        len = cols;
        if ($urandom_range(0, 3) == 0) len = cols + 1;
        if ($urandom_range(0, 5) == 0 && cols > 1) len = cols - 1;
        for (int b = 0; b < len; b++) begin
          bit lp, lc;
          if ($urandom_range(0, 3) == 0) begin
            bubble();
            if (r > 0 || b > 0) begin
              mode = 4'($urandom); gain_r = 8'($urandom); frame_cols = 12'($urandom_range(1, 5));
            end
          end
          lp = (r == rows - 1) && (b == len - 1);
          lc = (b == len - 1) && !(lp && $urandom_range(0, 3) == 0);
          beat($urandom_range(0, 255), $urandom_range(0, 3), lc, lp);
        end
        if (f % 10 == 7 && r == 0 && rows > 1) begin
          do_reset();
          abort = 1'b1;
        end
      end
    end

    // drain the scoreboard with a bounded wait
    bubble();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_scoreboard", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/isp_frame_gain.md
ISP_FRAME_GAIN -- requirements
Module: isp_frame_gain

Interface
REQ-001 Parameter COLOR_DEPTH, default 8: pixel width in bits.
REQ-002 Parameter GAIN_W, default 8: per-channel gain width, unsigned fixed point.
REQ-003 Parameter GAIN_FRAC, default 6: fractional bits of gain; 2^GAIN_FRAC = unity.
REQ-004 Parameter COL_W, default 12: width of column/row counters and frame_cols.
REQ-005 clk  in  1  the single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-high: level 1 sampled at clk edge resets the block.
REQ-007 pixel_in  in  COLOR_DEPTH  input pixel value.
REQ-008 valid_in  in  1  input beat qualifier; no backpressure.
REQ-009 color_in  in  2  00=R, 01=G, 10=B, 11=reserved.
REQ-010 last_col_in  in  1  beat is last of its row.
REQ-011 last_pic_in  in  1  beat is last of the frame.
REQ-012 mode  in  4  bit0 bypass, bit1 gain enable, bit2 size-check enable, bit3 reserved (ignored).
REQ-013 gain_r / gain_g / gain_b  in  GAIN_W each  channel gains.
REQ-014 frame_cols  in  COL_W  expected beats per row.
REQ-015 pixel_out, valid_out, color_out, last_col_out, last_pic_out  out  same widths as inputs  processed stream.
REQ-016 frame_done  out  1  one-cycle pulse coincident with the output last_pic beat.
REQ-017 size_err  out  1  sticky row-length mismatch flag for the current/last frame.
REQ-018 row_count  out  COL_W  rows seen in the last completed frame.

Function
REQ-019 Latency SHALL be exactly 2 cycles from input beat to output beat, in every mode; valid_in=0 cycles SHALL propagate as bubbles with valid_out=0.
REQ-020 FSM SHALL have states IDLE and ACTIVE; reset enters IDLE.
REQ-021 In IDLE, the first valid_in beat SHALL latch mode, gain_r/g/b, and frame_cols into shadow registers and move to ACTIVE; that beat is processed with the newly latched values.
REQ-022 In ACTIVE, changes on mode, gains, or frame_cols SHALL be ignored until the next frame.
REQ-023 A valid beat with last_pic_in=1 SHALL return the FSM to IDLE on the next cycle; a single-beat frame (first beat carries last_pic_in) SHALL latch and end in one beat.
REQ-024 Bypass (shadow bit0=1) SHALL pass pixel_in unchanged; bypass overrides gain enable.
REQ-025 Gain (bit1=1, bit0=0): out = min((pixel*gain + 2^(GAIN_FRAC-1)) >> GAIN_FRAC, 2^COLOR_DEPTH-1), with gain selected by color_in; product width COLOR_DEPTH+GAIN_W, no intermediate truncation.
REQ-026 color_in=11 or bit1=0 SHALL pass pixel unchanged; gain=0 SHALL yield 0.
REQ-027 color, last_col, last_pic SHALL be delayed 2 cycles alongside pixel; they are meaningful only when valid_out=1.
REQ-028 col_cnt SHALL increment per valid beat and clear after a beat with last_col_in or last_pic_in; row_cnt SHALL increment on each such row-ending beat.
REQ-029 last_pic_in without last_col_in SHALL be treated as end of row.
REQ-030 With size check enabled, size_err SHALL set when a row-ending beat has col_cnt+1 != frame_cols, or when col_cnt+1 reaches frame_cols without last_col_in; it SHALL clear only on the first beat of the next frame or reset.
REQ-031 row_count SHALL update with the completed frame's row total on the cycle frame_done pulses; frame_done SHALL not pulse otherwise.
REQ-032 Counters SHALL saturate at 2^COL_W-1, no wrap.

Reset
REQ-033 On rst_n=1: FSM IDLE; all outputs 0; pipeline, counters, shadow registers cleared; in-flight beats dropped with no valid_out after reset.
REQ-034 Reset asserted mid-frame SHALL discard the frame; the next valid beat starts a new frame.

Verification
REQ-035 Gain path: mode=0010, gain_r=128, pixel 100 R -> pixel_out 200 two cycles later; pixel 200 R -> 255 (saturate).
REQ-036 Bypass precedence: mode=0011, gain_g=0, pixel 77 G -> 77; color 11 with gain mode -> unchanged.
REQ-037 Frame-boundary latching: change gain_b 64->32 mid-frame -> current frame keeps unity; next frame pixel 80 B -> 40.
REQ-038 Size check: frame_cols=4, mode=0100, row of 3 beats ending last_col -> size_err=1 held until next frame's first beat.
REQ-039 Frame end: 3 rows x 4 cols, bubbles interleaved -> frame_done one pulse with last_pic_out, row_count=3.
REQ-040 Reset mid-frame after 5 beats -> no further valid_out; new frame starts with row/col counts from 0.
